// File: rtl/pack_collect_fifo_if.sv
// Trace-side and packet-side signal bundle for the trace packet collector.
// The slave modport is the collector; the master modport is its environment.
interface pack_collect_fifo_if #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned CNT_W      = 8
);
    // Trace front end
    logic                  TraceAvail;
    logic                  TraceNext;
    logic [DATA_W-1:0]     TraceIn;
    logic                  TraceSync;
    // Packet processor
    logic                  PacketAvail;
    logic                  PacketNext;
    logic                  PacketNextWd;
    logic [DATA_W-1:0]     PacketOut;
    logic                  PacketLast;
    logic [7:0]            PacketFinal;
    // Status and statistics
    logic [DEPTH_LOG2:0]   FillLevel;
    logic                  Overflow;
    logic [CNT_W-1:0]      DropCount;
    logic                  ClrStats;

    modport master (
        output TraceAvail, TraceIn, TraceSync, PacketNext, PacketNextWd, ClrStats,
        input  TraceNext, PacketAvail, PacketOut, PacketLast, PacketFinal, FillLevel,
               Overflow, DropCount
    );

    modport slave (
        input  TraceAvail, TraceIn, TraceSync, PacketNext, PacketNextWd, ClrStats,
        output TraceNext, PacketAvail, PacketOut, PacketLast, PacketFinal, FillLevel,
               Overflow, DropCount
    );
endinterface

// File: rtl/pack_collect_fifo.sv
// Trace packet collector: assembles trace words into fixed-size frames, buffers up
// to 2^DEPTH_LOG2 frames, drops whole frames on overflow and serves the oldest
// frame word by word. The claimed frame keeps its slot until fully read or
// replaced by the next claim.
module pack_collect_fifo #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned FRAME_BYTES = 16,
    parameter int unsigned DEPTH_LOG2  = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    pack_collect_fifo_if.slave bus
);
    localparam int unsigned WORDS = FRAME_BYTES * 8 / DATA_W;
    localparam int unsigned WO_W  = $clog2(WORDS);
    localparam int unsigned SLOTS = 1 << DEPTH_LOG2;
    localparam int unsigned PTR_W = DEPTH_LOG2 + 1;

    localparam logic [PTR_W-1:0] PtrOne  = PTR_W'(1);
    localparam logic [PTR_W-1:0] FullLvl = PTR_W'(SLOTS);
    localparam logic [WO_W-1:0]  WoOne   = WO_W'(1);
    localparam logic [WO_W-1:0]  WoLast  = WO_W'(WORDS - 1);
    localparam logic [WO_W:0]    RoOne   = (WO_W + 1)'(1);
    localparam logic [WO_W:0]    RoLast  = (WO_W + 1)'(WORDS - 1);
    localparam logic [WO_W:0]    RoEnd   = (WO_W + 1)'(WORDS);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    typedef enum logic {StIdle, StGet} rx_state_e;

    rx_state_e              state_q, state_d;
    logic                   trace_next;
    // Write side
    logic [PTR_W-1:0]       wp_q, wp_d;
    logic [WO_W-1:0]        wo_q, wo_d;
    logic                   drop_q, drop_d;
    logic [WO_W-1:0]        wr_off;
    logic                   drop_cur, drop_ev, mem_we, fb_we, full_chk;
    logic [PTR_W-1:0]       fill_post;
    // Read side
    logic [PTR_W-1:0]       rp_q, rp_d;
    logic [PTR_W-1:0]       rel_q, rel_d;
    logic                   hold_q, hold_d;
    logic [DEPTH_LOG2-1:0]  hold_slot_q, hold_slot_d;
    logic [WO_W:0]          ro_q, ro_d;
    logic [DATA_W-1:0]      pkt_out_q, pkt_out_d;
    logic                   pkt_last_q, pkt_last_d;
    logic [7:0]             pkt_final_q, pkt_final_d;
    logic                   pkt_avail;
    // Statistics
    logic                   ovf_q, ovf_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    // Storage
    logic [DATA_W-1:0]      mem_q [SLOTS][WORDS];
    logic [7:0]             fb_q  [SLOTS];

    assign pkt_avail = (wp_q != rp_q);

    // Rx handshake: request one word, sample it the following cycle.
    always_comb begin
        state_d    = state_q;
        trace_next = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.TraceAvail) begin
                    trace_next = 1'b1;
                    state_d    = StGet;
                end
            end
            StGet: state_d = StIdle;
        endcase
    end

    // Claim / word-read handling; PacketNext takes priority over PacketNextWd.
    always_comb begin
        rp_d        = rp_q;
        rel_d       = rel_q;
        hold_d      = hold_q;
        hold_slot_d = hold_slot_q;
        ro_d        = ro_q;
        pkt_out_d   = pkt_out_q;
        pkt_last_d  = pkt_last_q;
        pkt_final_d = pkt_final_q;
        if (bus.PacketNext) begin
            if (pkt_avail) begin
                if (hold_q) begin
                    rel_d = rel_q + PtrOne;
                end
                hold_slot_d = rp_q[DEPTH_LOG2-1:0];
                rp_d        = rp_q + PtrOne;
                ro_d        = '0;
                hold_d      = 1'b1;
                pkt_final_d = fb_q[rp_q[DEPTH_LOG2-1:0]];
            end
        end else if (bus.PacketNextWd && hold_q && (ro_q < RoEnd)) begin
            pkt_out_d  = mem_q[hold_slot_q][ro_q[WO_W-1:0]];
            pkt_last_d = (ro_q == RoLast);
            ro_d       = ro_q + RoOne;
            if (ro_q == RoLast) begin
                rel_d  = rel_q + PtrOne;
                hold_d = 1'b0;
            end
        end
    end

    // Frame assembly, resync and drop decision; the full check sees this cycle's release.
    always_comb begin
        wp_d      = wp_q;
        wo_d      = wo_q;
        drop_d    = drop_q;
        wr_off    = wo_q;
        drop_cur  = drop_q;
        drop_ev   = 1'b0;
        mem_we    = 1'b0;
        fb_we     = 1'b0;
        fill_post = wp_q - rel_d;
        full_chk  = (fill_post == FullLvl);
        if (state_q == StGet) begin
            wr_off   = bus.TraceSync ? '0 : wo_q;
            drop_cur = (wr_off == '0) ? full_chk : drop_q;
            mem_we   = ~drop_cur;
            if (wr_off == WoLast) begin
                wo_d   = '0;
                drop_d = 1'b0;
                if (drop_cur) begin
                    drop_ev = 1'b1;
                end else begin
                    wp_d  = wp_q + PtrOne;
                    fb_we = 1'b1;
                end
            end else begin
                wo_d   = wr_off + WoOne;
                drop_d = drop_cur;
            end
        end else if (bus.TraceSync) begin
            wo_d   = '0;
            drop_d = 1'b0;
        end
    end

    // Sticky overflow and saturating drop counter; a coincident drop beats the clear.
    always_comb begin
        ovf_d = ovf_q;
        cnt_d = cnt_q;
        if (bus.ClrStats) begin
            ovf_d = 1'b0;
            cnt_d = '0;
        end
        if (drop_ev) begin
            ovf_d = 1'b1;
            if (cnt_d != '1) begin
                cnt_d = cnt_d + CntOne;
            end
        end
    end

    // Control and output state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            wp_q        <= '0;
            wo_q        <= '0;
            drop_q      <= 1'b0;
            rp_q        <= '0;
            rel_q       <= '0;
            hold_q      <= 1'b0;
            hold_slot_q <= '0;
            ro_q        <= '0;
            pkt_out_q   <= '0;
            pkt_last_q  <= 1'b0;
            pkt_final_q <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            wp_q        <= wp_d;
            wo_q        <= wo_d;
            drop_q      <= drop_d;
            rp_q        <= rp_d;
            rel_q       <= rel_d;
            hold_q      <= hold_d;
            hold_slot_q <= hold_slot_d;
            ro_q        <= ro_d;
            pkt_out_q   <= pkt_out_d;
            pkt_last_q  <= pkt_last_d;
            pkt_final_q <= pkt_final_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
        end
    end

    // Frame storage and per-slot final byte; contents need no reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wp_q[DEPTH_LOG2-1:0]][wr_off] <= bus.TraceIn;
        end
        if (fb_we) begin
            fb_q[wp_q[DEPTH_LOG2-1:0]] <= bus.TraceIn[DATA_W-1 -: 8];
        end
    end

    // The request strobe is combinational, so force it low while reset is held.
    assign bus.TraceNext   = trace_next & rst;
    assign bus.PacketAvail = pkt_avail;
    assign bus.PacketOut   = pkt_out_q;
    assign bus.PacketLast  = pkt_last_q;
    assign bus.PacketFinal = pkt_final_q;
    assign bus.FillLevel   = wp_q - rel_q;
    assign bus.Overflow    = ovf_q;
    assign bus.DropCount   = cnt_q;
endmodule
